// File: rtl/sysop_pkg.sv
// Shared types for the system-op sequencer: request kinds, trap causes, FSM states
// and the request-to-sysop translation.
`ifndef SYSOP_NONE
// Sysop codes shared with the CSR unit; mirrors the definitions in its csr.vh.
`define SYSOP_NONE  5'h00
`define SYSOP_RET   5'h01
`define SYSOP_CSR_W 5'h02
`define SYSOP_CSR_S 5'h03
`define SYSOP_CSR_C 5'h04
`endif

package sysop_pkg;

    typedef enum logic [2:0] {
        K_ECALL   = 3'd0,
        K_EBREAK  = 3'd1,
        K_RET     = 3'd2,
        K_CSRW    = 3'd3,
        K_CSRS    = 3'd4,
        K_CSRC    = 3'd5,
        K_ILLEGAL = 3'd6,
        K_FAULT   = 3'd7
    } kind_e;

    localparam logic [3:0] CAUSE_IALIGN  = 4'd0;
    localparam logic [3:0] CAUSE_IACCESS = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
    localparam logic [3:0] CAUSE_ECALL_S = 4'd9;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
    localparam logic [3:0] CAUSE_IPF     = 4'd12;
    localparam logic [3:0] CAUSE_LPF     = 4'd13;
    localparam logic [3:0] CAUSE_SPF     = 4'd15;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        REDIRECT = 2'd2,
        DRAIN    = 2'd3
    } state_e;

    // Reserved privilege encoding 2 is handled as machine mode.
    function automatic logic [4:0] sysop_encode(input logic [2:0] kind,
                                                input logic [3:0] cause,
                                                input logic [1:0] priv);
        logic [4:0] op;
        op = {1'b1, CAUSE_ILLEGAL};
        case (kind)
            K_ECALL: begin
                if (priv == PRIV_U)      op = {1'b1, CAUSE_ECALL_U};
                else if (priv == PRIV_S) op = {1'b1, CAUSE_ECALL_S};
                else                     op = {1'b1, CAUSE_ECALL_M};
            end
            K_EBREAK:  op = {1'b1, CAUSE_BREAK};
            K_RET:     op = `SYSOP_RET;
            K_CSRW:    op = `SYSOP_CSR_W;
            K_CSRS:    op = `SYSOP_CSR_S;
            K_CSRC:    op = `SYSOP_CSR_C;
            K_FAULT:   op = {1'b1, cause};
            default:   op = {1'b1, CAUSE_ILLEGAL};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sysop_ctrl.sv
// Sequencer between execute and the CSR/trap unit: issues one sysop per request,
// returns CSR read data to writeback and drives redirect/flush on traps.
module sysop_ctrl
    import sysop_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [3:0]  req_cause,
    input  logic [63:0] req_pc,
    input  logic [63:0] req_tval,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_rd,
    input  logic [1:0]  priv,
    output logic [4:0]  csr_op,
    output logic [63:0] csr_pc,
    output logic [63:0] csr_tval,
    output logic [63:0] csr_wdata,
    input  logic [63:0] csr_rdata,
    input  logic        csr_r_valid,
    input  logic        csr_trap_en,
    input  logic [63:0] csr_trap_pc,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        redir_valid,
    output logic [63:0] redir_pc,
    input  logic        redir_ready,
    output logic        flush,
    output logic        busy
);

    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    state_e           state;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] drain_cnt;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // The csr_* operands are loaded at accept and cleared on leaving ISSUE,
    // so they are only non-zero during the single ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_q        <= '0;
            drain_cnt   <= '0;
            csr_op      <= `SYSOP_NONE;
            csr_pc      <= '0;
            csr_tval    <= '0;
            csr_wdata   <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            flush       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        csr_op    <= sysop_encode(req_kind, req_cause, priv);
                        csr_pc    <= req_pc;
                        csr_tval  <= req_tval;
                        csr_wdata <= req_wdata;
                        rd_q      <= req_rd;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    csr_op    <= `SYSOP_NONE;
                    csr_pc    <= '0;
                    csr_tval  <= '0;
                    csr_wdata <= '0;
                    if (csr_r_valid && (rd_q != 5'd0)) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= csr_rdata;
                    end
                    // A trap and a writeback can coexist (e.g. satp write refetch).
                    if (csr_trap_en) begin
                        redir_valid <= 1'b1;
                        redir_pc    <= csr_trap_pc;
                        flush       <= 1'b1;
                        state       <= REDIRECT;
                    end else begin
                        state <= IDLE;
                    end
                end
                REDIRECT: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        redir_pc    <= '0;
                        if (FLUSH_CYCLES > 0) begin
                            drain_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                            state     <= DRAIN;
                        end else begin
                            flush <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysop_ctrl.sv
// Directed bench for sysop_ctrl: CSR ops, ECALL/fault traps, stalled redirect,
// rd=0 suppression, back-to-back accept and reset during a redirect.
module tb_sysop_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [3:0]  req_cause;
    logic [63:0] req_pc, req_tval, req_wdata;
    logic [4:0]  req_rd;
    logic [1:0]  priv;
    logic [4:0]  csr_op;
    logic [63:0] csr_pc, csr_tval, csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_r_valid;
    logic        csr_trap_en;
    logic [63:0] csr_trap_pc;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        redir_ready;
    logic        flush;
    logic        busy;

    int total = 0;
    int bad   = 0;

    sysop_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_cause(req_cause), .req_pc(req_pc), .req_tval(req_tval),
        .req_wdata(req_wdata), .req_rd(req_rd), .priv(priv),
        .csr_op(csr_op), .csr_pc(csr_pc), .csr_tval(csr_tval), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_r_valid(csr_r_valid),
        .csr_trap_en(csr_trap_en), .csr_trap_pc(csr_trap_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] kind, input logic [3:0] cause,
                             input logic [63:0] pc, input logic [63:0] tval,
                             input logic [63:0] wdata, input logic [4:0] rd,
                             input logic [1:0] p);
        req_valid = 1'b1;
        req_kind  = kind;
        req_cause = cause;
        req_pc    = pc;
        req_tval  = tval;
        req_wdata = wdata;
        req_rd    = rd;
        priv      = p;
    endtask

    // kind, cause, priv -> expected sysop
    logic [2:0] enc_kind [7] = '{3'd0, 3'd0, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [3:0] enc_cause[7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    logic [1:0] enc_priv [7] = '{2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [4:0] enc_op   [7] = '{5'h19, 5'h1B, 5'h01, 5'h03, 5'h04, 5'h12, 5'h11};

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_kind = '0; req_cause = '0; req_pc = '0;
        req_tval = '0; req_wdata = '0; req_rd = '0; priv = '0;
        csr_rdata = '0; csr_r_valid = 1'b0; csr_trap_en = 1'b0; csr_trap_pc = '0;
        redir_ready = 1'b0;
        tick(); tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_csr_op", 64'(csr_op), 64'h00);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_redir", 64'(redir_valid), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_wb", 64'(wb_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        // CSRW mstatus, no trap
        drive_req(3'd3, 4'd0, 64'h1000, 64'h300, 64'h8, 5'd5, 2'd3);
        tick();
        req_valid = 1'b0;
        check("csrw_op", 64'(csr_op), 64'h02);
        check("csrw_tval", csr_tval, 64'h300);
        check("csrw_wdata", csr_wdata, 64'h8);
        check("csrw_pc", csr_pc, 64'h1000);
        check("csrw_ready_low", 64'(req_ready), 64'd0);
        csr_r_valid = 1'b1; csr_rdata = 64'h1800;
        tick();
        csr_r_valid = 1'b0; csr_rdata = '0;
        check("csrw_wb_valid", 64'(wb_valid), 64'd1);
        check("csrw_wb_rd", 64'(wb_rd), 64'd5);
        check("csrw_wb_data", wb_data, 64'h1800);
        check("csrw_op_gone", 64'(csr_op), 64'h00);
        check("csrw_no_flush", 64'(flush), 64'd0);
        check("csrw_ready_back", 64'(req_ready), 64'd1);
        tick();
        check("csrw_wb_one_cycle", 64'(wb_valid), 64'd0);

        // ECALL from U, redirect accepted immediately
        redir_ready = 1'b1;
        drive_req(3'd0, 4'd0, 64'h80001000, 64'h0, 64'h0, 5'd0, 2'd0);
        tick();
        req_valid = 1'b0;
        check("ecall_op", 64'(csr_op), 64'h18);
        check("ecall_pc", csr_pc, 64'h80001000);
        csr_trap_en = 1'b1; csr_trap_pc = 64'h80000100;
        tick();
        check("ecall_redir_valid", 64'(redir_valid), 64'd1);
        check("ecall_redir_pc", redir_pc, 64'h80000100);
        check("ecall_flush0", 64'(flush), 64'd1);
        check("ecall_no_wb", 64'(wb_valid), 64'd0);
        tick();
        check("ecall_redir_1cyc", 64'(redir_valid), 64'd0);
        check("ecall_flush1", 64'(flush), 64'd1);
        check("ecall_busy_drain", 64'(req_ready), 64'd0);
        tick();
        check("ecall_flush2", 64'(flush), 64'd1);
        tick();
        // trap_en is still high here and must be ignored outside ISSUE
        check("ecall_flush_end", 64'(flush), 64'd0);
        check("ecall_idle", 64'(req_ready), 64'd1);
        check("trap_ignored", 64'(redir_valid), 64'd0);
        csr_trap_en = 1'b0; csr_trap_pc = '0;

        // CSRW satp: writeback plus a stalled redirect
        redir_ready = 1'b0;
        drive_req(3'd3, 4'd0, 64'h2000, 64'h180, 64'h123, 5'd7, 2'd1);
        tick();
        req_valid = 1'b0;
        check("satp_tval", csr_tval, 64'h180);
        csr_r_valid = 1'b1; csr_rdata = 64'habc;
        csr_trap_en = 1'b1; csr_trap_pc = 64'h2004;
        tick();
        csr_r_valid = 1'b0; csr_rdata = '0;
        csr_trap_en = 1'b0; csr_trap_pc = '0;
        check("satp_wb_valid", 64'(wb_valid), 64'd1);
        check("satp_wb_data", wb_data, 64'habc);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("satp_hold_valid%0d", i), 64'(redir_valid), 64'd1);
            check($sformatf("satp_hold_pc%0d", i), redir_pc, 64'h2004);
            check($sformatf("satp_hold_ready%0d", i), 64'(req_ready), 64'd0);
            tick();
        end
        redir_ready = 1'b1;
        check("satp_hs_valid", 64'(redir_valid), 64'd1);
        check("satp_hs_pc", redir_pc, 64'h2004);
        tick();
        check("satp_after_hs", 64'(redir_valid), 64'd0);
        check("satp_drain_flush", 64'(flush), 64'd1);
        tick();
        check("satp_drain_ready", 64'(req_ready), 64'd0);
        tick();
        check("satp_idle", 64'(req_ready), 64'd1);
        check("satp_flush_off", 64'(flush), 64'd0);

        // FAULT load page fault, then EBREAK back-to-back
        drive_req(3'd7, 4'd13, 64'h3000, 64'hdead0000, 64'h0, 5'd0, 2'd0);
        tick();
        check("fault_op", 64'(csr_op), 64'h1D);
        check("fault_tval", csr_tval, 64'hdead0000);
        drive_req(3'd1, 4'd0, 64'h3004, 64'h0, 64'h0, 5'd0, 2'd3);
        tick();
        check("b2b_ready", 64'(req_ready), 64'd1);
        check("b2b_no_op", 64'(csr_op), 64'h00);
        tick();
        req_valid = 1'b0;
        check("ebreak_op", 64'(csr_op), 64'h13);
        check("ebreak_pc", csr_pc, 64'h3004);
        tick();

        // CSRS with rd=0 returns data but no writeback
        drive_req(3'd4, 4'd0, 64'h4000, 64'h340, 64'hf, 5'd0, 2'd3);
        tick();
        req_valid = 1'b0;
        csr_r_valid = 1'b1; csr_rdata = 64'h55;
        tick();
        csr_r_valid = 1'b0; csr_rdata = '0;
        check("rd0_no_wb", 64'(wb_valid), 64'd0);

        // Translation table
        for (int i = 0; i < 7; i++) begin
            drive_req(enc_kind[i], enc_cause[i], 64'h5000, 64'h0, 64'h0, 5'd0, enc_priv[i]);
            tick();
            req_valid = 1'b0;
            check($sformatf("enc_op%0d", i), 64'(csr_op), 64'(enc_op[i]));
            tick();
        end

        // Reset while in REDIRECT
        redir_ready = 1'b0;
        drive_req(3'd0, 4'd0, 64'h6000, 64'h0, 64'h0, 5'd0, 2'd1);
        tick();
        req_valid = 1'b0;
        csr_trap_en = 1'b1; csr_trap_pc = 64'h7000;
        tick();
        csr_trap_en = 1'b0; csr_trap_pc = '0;
        check("pre_rst_redir", 64'(redir_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_redir", 64'(redir_valid), 64'd0);
        check("mid_rst_pc", redir_pc, 64'd0);
        check("mid_rst_flush", 64'(flush), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        drive_req(3'd5, 4'd0, 64'h8000, 64'h341, 64'h2, 5'd9, 2'd3);
        tick();
        req_valid = 1'b0;
        check("post_rst_op", 64'(csr_op), 64'h04);
        csr_r_valid = 1'b1; csr_rdata = 64'h77;
        tick();
        csr_r_valid = 1'b0; csr_rdata = '0;
        check("post_rst_wb", 64'(wb_valid), 64'd1);
        check("post_rst_wb_rd", 64'(wb_rd), 64'd9);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysop_ctrl.md
# sysop_ctrl

Sequencer between the execute stage and the CSR/trap unit. It accepts one system request at a time: ECALL, EBREAK, xRET, CSR read-modify-write, illegal instruction or fetch/memory fault. It translates the request into a single-cycle 5-bit sysop for the CSR unit. It then returns the CSR read data to writeback and, when the CSR unit signals a trap, drives a held redirect to fetch and a pipeline flush.

## Interface
- FLUSH_CYCLES, 2, extra flush cycles after the redirect handshake; 0 means no drain state.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  execute stage holds a system request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_kind  in  3  one of ECALL, EBREAK, RET, CSRW, CSRS, CSRC, ILLEGAL, FAULT
- req_cause  in  4  exception cause, used only for FAULT
- req_pc  in  64  pc of the instruction
- req_tval  in  64  CSR address (CSR ops), fault address (FAULT), instruction bits (ILLEGAL)
- req_wdata  in  64  CSR write/set/clear operand
- req_rd  in  5  destination register for CSR ops
- priv  in  2  current privilege from the CSR unit
- csr_op  out  5  sysop; bit4 = exception, bits3:0 = cause
- csr_pc, csr_tval, csr_wdata  out  64 each  operands for the CSR unit
- csr_rdata  in  64  CSR read data
- csr_r_valid  in  1  read data valid
- csr_trap_en  in  1  trap/return/refetch requested by the CSR unit
- csr_trap_pc  in  64  target pc for the trap, return or refetch
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  writeback register
- wb_data  out  64  writeback data
- redir_valid  out  1  redirect pending to fetch
- redir_pc  out  64  redirect target
- redir_ready  in  1  fetch accepts the redirect
- flush  out  1  squash younger pipeline contents
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, REDIRECT, DRAIN.
- **IDLE**
  - req_ready=1.
  - On handshake: register the request, latch priv, and go to ISSUE.
- **Request translation** (registered at accept):
  - ECALL → {1, cause}, where cause = 8 if priv=U, 9 if priv=S, 11 if priv=M.
  - EBREAK → {1, 3}.
  - ILLEGAL → {1, 2}.
  - FAULT → {1, req_cause}.
  - RET → `SYSOP_RET.
  - CSRW/CSRS/CSRC → `SYSOP_CSR_W / `SYSOP_CSR_S / `SYSOP_CSR_C.
  - An undefined req_kind is treated as ILLEGAL.
- **ISSUE** (exactly one cycle)
  - csr_op, csr_pc, csr_tval and csr_wdata are driven from the registered request.
  - csr_tval carries the CSR address for CSR ops and the fault value for exceptions.
  - Sample csr_r_valid and csr_rdata:
    - If csr_r_valid and rd != 0, then wb_valid=1 on the next cycle with the registered rd and data.
    - If rd = 0, no writeback pulse is issued.
  - Sample csr_trap_en and csr_trap_pc:
    - trap_en=1 → load redir_pc and go to REDIRECT.
    - Otherwise → go to IDLE.
  - A CSR write to satp reports trap_en with pc+4; it gets both a writeback and a redirect.
- **REDIRECT**
  - redir_valid=1 and flush=1.
  - redir_pc is held stable until redir_ready.
  - On handshake: go to DRAIN if FLUSH_CYCLES>0, else to IDLE.
- **DRAIN**
  - flush=1.
  - A down-counter loaded with FLUSH_CYCLES-1 runs; go to IDLE in the cycle the count reaches 0.
- **Outside ISSUE:** csr_op = `SYSOP_NONE (5'h00); csr_pc, csr_tval and csr_wdata are 0.

## Timing
- **Reset values:** state IDLE, req_ready=1, csr_op=`SYSOP_NONE, and every other output 0.
- **Latency**
  - Accept at cycle N → csr_op valid at N+1.
  - Writeback pulse at N+2.
  - redir_valid first high at N+2.
- **Redirect handshake**
  - If redir_ready is already high at N+2, the handshake completes that cycle and REDIRECT lasts exactly one cycle.
  - Otherwise REDIRECT lasts until redir_ready is seen.
- **Flush duration:** flush is high from N+2 through the redirect handshake cycle plus FLUSH_CYCLES further cycles.
- **Back-to-back requests:** req_ready returns high the cycle after leaving the last busy state. The no-trap minimum is 2 cycles between accepts.
- **Reset mid-operation:** the redirect is dropped, the pending writeback is discarded, and the block is in IDLE on the first cycle after deassertion.
- **csr_trap_en outside ISSUE** is ignored.

## Structure
- Package sysop_pkg holds:
  - the req_kind enum;
  - the cause constants (IALIGN 0, IACCESS 1, ILLEGAL 2, BREAK 3, ECALL_U 8, ECALL_S 9, ECALL_M 11, page faults 12/13/15);
  - the state enum.
- The sysop codes (`SYSOP_NONE, `SYSOP_RET, `SYSOP_CSR_*) stay in csr.vh and are shared with the CSR unit.
- No sub-module; the drain counter is inline, $clog2(FLUSH_CYCLES+1) bits wide.

## Test plan
- CSRW, addr 0x300, wdata 0x8, rd=5, CSR returns rdata 0x1800 with no trap:
  - csr_op=`SYSOP_CSR_W for exactly 1 cycle;
  - wb_valid at N+2 with rd=5, data=0x1800;
  - no flush.
- ECALL at priv=U, pc 0x80001000, CSR trap_pc 0x80000100, redir_ready tied high:
  - csr_op=5'h18;
  - redir_pc=0x80000100 held for 1 cycle;
  - flush high for 3 cycles with FLUSH_CYCLES=2.
- CSRW to satp (0x180), pc 0x2000, trap_pc 0x2004, redir_ready low for 4 cycles:
  - wb pulse issued;
  - redir_valid and redir_pc=0x2004 stable for 5 cycles;
  - req_ready=0 throughout.
- FAULT cause 13 with tval 0xdead0000: csr_op=5'h1D and csr_tval=0xdead0000 in ISSUE.
- CSRS with rd=0: no wb_valid pulse.
- Reset asserted while in REDIRECT: all outputs go to reset values immediately, and the next request is accepted normally.
